// File: rtl/cpu_flag_pkg.sv
// cpu_flag_pkg: shared constants for the flag unit.
//   - condition-code encodings COND_AL..COND_NV
//   - flag bit positions in the {C,Z,V,S} status vector
//   - flag_op encodings (none / CLC / STC / CMC)
package cpu_flag_pkg;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_CS = 4'h3;
  localparam logic [3:0] COND_CC = 4'h4;
  localparam logic [3:0] COND_MI = 4'h5;
  localparam logic [3:0] COND_PL = 4'h6;
  localparam logic [3:0] COND_VS = 4'h7;
  localparam logic [3:0] COND_VC = 4'h8;
  localparam logic [3:0] COND_HI = 4'h9;
  localparam logic [3:0] COND_LS = 4'hA;
  localparam logic [3:0] COND_GE = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GT = 4'hD;
  localparam logic [3:0] COND_LE = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_S = 0;

  typedef enum logic [1:0] {
    FOP_NONE = 2'b00,
    FOP_CLC  = 2'b01,
    FOP_STC  = 2'b10,
    FOP_CMC  = 2'b11
  } flag_op_e;

endpackage

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: combinational branch-condition evaluator.
// Ports:
//   cond      in  4  condition code (COND_AL..COND_NV)
//   flags     in  4  status vector {C,Z,V,S}
//   cond_true out 1  condition result
// C is the borrow after b-a, so HI/LS are the unsigned compares.
module flag_cond_eval
  import cpu_flag_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic c, z, v, s;

  assign c = flags[FLG_C];
  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign s = flags[FLG_S];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = s;
      COND_PL: cond_true = ~s;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = ~c & ~z;
      COND_LS: cond_true = c | z;
      COND_GE: cond_true = (s == v);
      COND_LT: cond_true = (s != v);
      COND_GT: cond_true = ~z & (s == v);
      COND_LE: cond_true = z | (s != v);
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: status register, carry ops, branch condition and flag stack.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   alu_c/z/v/s                ALU flag inputs
//   flag_we, flag_mask[3:0]    masked latch of ALU flags, mask order {c,z,v,s}
//   flag_op[1:0]               none / CLC / STC / CMC on C
//   push, pop                  flag stack save / restore
//   err_clr                    clear sticky stk_err
//   use_carry                  instruction consumes carry
//   cond[3:0]                  condition code to evaluate
//   cond_true, cin             condition result, ALU carry-in
//   flags[3:0]                 status register {C,Z,V,S}
//   stk_full, stk_empty, stk_err  stack status
// Build option: define FLAG_BYPASS_EN to let cond_true/cin see the
// next-cycle flag value (zero-latency compare-and-branch).
module flag_unit
  import cpu_flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_s,
  input  logic       flag_we,
  input  logic [3:0] flag_mask,
  input  logic [1:0] flag_op,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  input  logic       use_carry,
  input  logic [3:0] cond,
  output logic       cond_true,
  output logic       cin,
  output logic [3:0] flags,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [3:0]    flags_q, flags_d;
  logic [3:0]    stk_q [STACK_DEPTH];
  logic [PW-1:0] ptr_q;
  logic          err_q;

  logic          full, empty;
  logic          push_ok, pop_ok, err_set;
  logic [IW-1:0] top_idx, wr_idx;
  logic [3:0]    alu_vec;
  logic [3:0]    flags_eval;

  assign full    = (ptr_q == PW'(STACK_DEPTH));
  assign empty   = (ptr_q == '0);
  // Simultaneous push and pop cancel: the stack is left as it is.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err_set = (push & ~pop & full) | (pop & ~push & empty);
  assign top_idx = IW'(ptr_q - PW'(1));
  assign wr_idx  = IW'(ptr_q);
  assign alu_vec = {alu_c, alu_z, alu_v, alu_s};

  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = stk_q[top_idx];
    end else begin
      if (flag_we)
        flags_d = (flags_q & ~flag_mask) | (alu_vec & flag_mask);
      // Carry op applies to the C produced by the masked write above.
      case (flag_op_e'(flag_op))
        FOP_CLC: flags_d[FLG_C] = 1'b0;
        FOP_STC: flags_d[FLG_C] = 1'b1;
        FOP_CMC: flags_d[FLG_C] = ~flags_d[FLG_C];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 4'b0000;
    end else begin
      flags_q <= flags_d;
      if (push_ok) begin
        stk_q[wr_idx] <= flags_q;
        ptr_q         <= ptr_q + PW'(1);
      end else if (pop_ok) begin
        ptr_q <= ptr_q - PW'(1);
      end
      if (err_set)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags_eval = flags_d;
`else
  assign flags_eval = flags_q;
`endif

  flag_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags_eval),
    .cond_true (cond_true)
  );

  assign cin       = use_carry & flags_eval[FLG_C];
  assign flags     = flags_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign stk_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;
  import cpu_flag_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_c = 0, alu_z = 0, alu_v = 0, alu_s = 0;
  logic       flag_we = 0;
  logic [3:0] flag_mask = 0;
  logic [1:0] flag_op = 0;
  logic       push = 0, pop = 0, err_clr = 0, use_carry = 0;
  logic [3:0] cond = 0;
  logic       cond_true, cin, stk_full, stk_empty, stk_err;
  logic [3:0] flags;

  always #5 clk = ~clk;

  flag_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_s(alu_s),
    .flag_we(flag_we), .flag_mask(flag_mask), .flag_op(flag_op),
    .push(push), .pop(pop), .err_clr(err_clr), .use_carry(use_carry),
    .cond(cond), .cond_true(cond_true), .cin(cin), .flags(flags),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  typedef struct packed {
    logic [3:0] flags;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stk [DEPTH];
  int         m_ptr;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic fc, fz, fv, fs;
    fc = f[3]; fz = f[2]; fv = f[1]; fs = f[0];
    case (c)
      4'h0: return 1'b1;
      4'h1: return fz;
      4'h2: return !fz;
      4'h3: return fc;
      4'h4: return !fc;
      4'h5: return fs;
      4'h6: return !fs;
      4'h7: return fv;
      4'h8: return !fv;
      4'h9: return !fc && !fz;
      4'hA: return fc || fz;
      4'hB: return fs == fv;
      4'hC: return fs != fv;
      4'hD: return !fz && (fs == fv);
      4'hE: return fz || (fs != fv);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_ptr   = 0;
    m_err   = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_stk[i] = 4'b0000;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.flags = m_flags;
    e.full  = (m_ptr == DEPTH);
    e.empty = (m_ptr == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic check_state(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_flags"}, 32'(flags), 32'(e.flags));
    chk({tag, "_full"},  32'(stk_full), 32'(e.full));
    chk({tag, "_empty"}, 32'(stk_empty), 32'(e.empty));
    chk({tag, "_err"},   32'(stk_err), 32'(e.err));
  endtask

  // One clock of stimulus; the model's expectation is queued at drive time
  // and compared after the edge.
  task automatic step(input logic we, input logic [3:0] mask, input logic [3:0] alu,
                      input logic [1:0] op, input logic ps, input logic pp,
                      input logic ec, input string tag);
    logic [3:0] nf;
    logic       set_err;
    @(negedge clk);
    flag_we = we; flag_mask = mask; flag_op = op;
    {alu_c, alu_z, alu_v, alu_s} = alu;
    push = ps; pop = pp; err_clr = ec;

    nf = m_flags;
    if (pp && !ps && m_ptr != 0) begin
      nf = m_stk[m_ptr-1];
    end else begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (mask[b]) nf[b] = alu[b];
      end
      if (op == 2'b01) nf[3] = 1'b0;
      else if (op == 2'b10) nf[3] = 1'b1;
      else if (op == 2'b11) nf[3] = !nf[3];
    end
    set_err = (ps && !pp && m_ptr == DEPTH) || (pp && !ps && m_ptr == 0);
    if (ps && !pp && m_ptr < DEPTH) begin
      m_stk[m_ptr] = m_flags;
      m_ptr++;
    end else if (pp && !ps && m_ptr > 0) begin
      m_ptr--;
    end
    if (set_err) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    m_flags = nf;
    sb.push_back(model_exp());

    @(posedge clk);
    #1;
    flag_we = 0; flag_mask = 0; flag_op = 0; push = 0; pop = 0; err_clr = 0;
    #1;
    check_state(tag);
  endtask

  task automatic check_cond(input logic [3:0] c, input string tag);
    cond = c;
    #1;
    chk(tag, 32'(cond_true), 32'(cond_ref(c, m_flags)));
  endtask

  task automatic check_cin(input logic u, input string tag);
    use_carry = u;
    #1;
    chk(tag, 32'(cin), 32'(u & m_flags[3]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] vals [4];
    vals[0] = 4'hA; vals[1] = 4'h3; vals[2] = 4'h6; vals[3] = 4'hF;

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(model_exp());
    check_state("rst_hold");
    check_cond(COND_AL, "rst_cond_al");
    check_cond(COND_HI, "rst_cond_hi");
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.push_back(model_exp());
    check_state("rst_rel");

    // 1: full-mask latch
    step(1, 4'b1111, 4'b1001, 2'b00, 0, 0, 0, "t1_we");
    chk("t1_flags_const", 32'(flags), 32'h9);
    check_cond(COND_CS, "t1_cs");
    check_cond(COND_HI, "t1_hi");

    // 2: partial mask, CMC, cin
    step(1, 4'b0100, 4'b0111, 2'b00, 0, 0, 0, "t2_mask");
    chk("t2_flags_const", 32'(flags), 32'hD);
    step(0, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, "t2_cmc");
    chk("t2_cmc_const", 32'(flags), 32'h5);
    check_cin(1'b1, "t2_cin0");
    step(0, 4'b1111, 4'b0000, 2'b10, 0, 0, 0, "t2_stc_we0");
    check_cin(1'b1, "t2_cin1");
    check_cin(1'b0, "t2_cin_nouse");
    step(1, 4'b1000, 4'b0000, 2'b11, 0, 0, 0, "t2_we_cmc");
    step(0, 4'b0000, 4'b0000, 2'b10, 0, 0, 0, "t2_stc");

    // 3: fill stack, overflow, LIFO restore
    for (int i = 0; i < 4; i++) step(1, 4'b1111, vals[i], 2'b00, 1, 0, 0, "t3_push");
    chk("t3_full_const", 32'(stk_full), 32'h1);
    step(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, "t3_push_full");
    chk("t3_err_const", 32'(stk_err), 32'h1);
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, "t3_errclr");
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, "t3_pop");
    chk("t3_last_pop_const", 32'(flags), 32'hD);

    // 4: pop on empty still takes the ALU write; set beats clear
    step(1, 4'b1111, 4'b0010, 2'b00, 0, 1, 0, "t4_pop_empty");
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, "t4_set_dom");
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, "t4_errclr");

    // 5: push+pop together, pop beats flag_we
    step(0, 4'b0000, 4'b0000, 2'b00, 1, 1, 0, "t5_pp_empty");
    step(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, "t5_push");
    step(1, 4'b1111, 4'b1100, 2'b00, 1, 1, 0, "t5_pp_we");
    step(1, 4'b1111, 4'b0000, 2'b11, 0, 1, 0, "t5_pop_we");
    chk("t5_pop_wins_const", 32'(flags), 32'h2);

    // 6: signed compares and full sweep
    step(1, 4'b1111, 4'b0001, 2'b00, 0, 0, 0, "t6_s1v0");
    check_cond(COND_LT, "t6_lt");
    check_cond(COND_GE, "t6_ge");
    step(1, 4'b1111, 4'b0100, 2'b00, 0, 0, 0, "t6_z1");
    check_cond(COND_LE, "t6_le");
    check_cond(COND_GT, "t6_gt");
    for (int f = 0; f < 16; f++) begin
      step(1, 4'b1111, 4'(f), 2'b00, 0, 0, 0, "t6_sweep_we");
      for (int c = 0; c < 16; c++) check_cond(4'(c), "t6_sweep");
    end

    // async reset mid-operation
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, "t7_pop_empty");
    step(1, 4'b1111, 4'b1011, 2'b00, 1, 0, 0, "t7_push");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_exp());
    check_state("t7_async_rst");
    check_cond(COND_AL, "t7_cond");
    @(negedge clk);
    rst = 1'b0;
    step(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, "t7_pop_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
